mmio_bus_router: RTL and testbench

Single-outstanding MMIO request router between the core's data memory port and the MMIO devices. It sits directly upstream of the UART transmit MMIO port.
- Latches one core request and decodes its address to RAM, the UART TX port, or unmapped.
- Drives the selected device's ready/valid request channel and waits for that device's response.
- Returns one registered response to the core.
- Unmapped addresses get an error response without touching any device.

---
 rtl/mmio_bus_router_if.sv | 64 ++++++
 rtl/mmio_bus_router.sv | 202 ++++++++++++++++++++
 tb/tb_mmio_bus_router.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_bus_router_if.sv
// Bus bundles for mmio_bus_router.
//   mmio_core_if : core data-memory port <-> router
//   mmio_dev_if  : router <-> one MMIO device (RAM or UART TX)
//
// Handshake rules for every channel in this file:
//   A request transfers on a rising clk edge where req_valid and req_ready
//   are both high. Once req_valid is raised it stays high, and addr/wen/wdata
//   stay stable, until that transfer edge. req_ready may toggle freely and
//   must not depend on req_valid. resp_valid is a per-cycle qualifier with
//   no back-pressure: the receiver samples rdata (and err) in any cycle it
//   is high.

interface mmio_core_if #(
    parameter int unsigned XLEN = 32
);
    logic            req_ready;
    logic            req_valid;
    logic [XLEN-1:0] req_addr;
    logic            req_wen;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_err;

    // Core side issues requests and consumes responses.
    modport master (
        input  req_ready,
        output req_valid, req_addr, req_wen, req_wdata,
        input  resp_valid, resp_rdata, resp_err
    );

    // Router side accepts requests and produces responses.
    modport slave (
        output req_ready,
        input  req_valid, req_addr, req_wen, req_wdata,
        output resp_valid, resp_rdata, resp_err
    );
endinterface

interface mmio_dev_if #(
    parameter int unsigned XLEN = 32
);
    logic            req_ready;
    logic            req_valid;
    logic [XLEN-1:0] req_addr;
    logic            req_wen;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;

    // Router side issues device requests.
    modport master (
        output req_valid, req_addr, req_wen, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata
    );

    // Device side.
    modport slave (
        input  req_valid, req_addr, req_wen, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata
    );
endinterface

// File: rtl/mmio_bus_router.sv
// mmio_bus_router: single-outstanding MMIO request router.
// Latches one core request, decodes it to the UART TX register, the RAM
// window or "unmapped", runs the selected device's request/response
// exchange and returns one registered response to the core. Unmapped
// addresses are answered with an error without touching any device.
//
// Optional build macro MMIO_ROUTER_TIMEOUT_EN: adds a cycle counter that
// aborts a device exchange after TIMEOUT_CYCLES cycles with an error
// response. Without the macro the router waits on a device indefinitely.
//
// o_dbg_state exposes the FSM state: 0 IDLE, 1 ISSUE, 2 WAIT_RESP, 3 RESPOND.

module mmio_bus_router #(
    parameter int unsigned     XLEN           = 32,
    parameter logic [XLEN-1:0] MEM_BASE       = 32'h0000_0000,
    parameter logic [XLEN-1:0] MEM_SIZE       = 32'h0001_0000,
    parameter logic [XLEN-1:0] UART_TX_ADDR   = 32'hff00_0000,
    parameter int unsigned     TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    mmio_core_if.slave  io_core,
    mmio_dev_if.master  io_mem,
    mmio_dev_if.master  io_uart,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_RESP = 2'd2,
        S_RESPOND   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    // Latched request and captured response.
    logic [XLEN-1:0] r_addr;
    logic            r_wen;
    logic [XLEN-1:0] r_wdata;
    logic            r_sel_uart;
    logic [XLEN-1:0] r_rdata;
    logic            r_err;

    logic            w_req_ready;
    logic            w_accept;
    logic [XLEN-1:0] w_mem_off;
    logic            w_hit_uart;
    logic            w_hit_mem;
    logic            w_mapped;
    logic            w_dev_ready;
    logic            w_dev_resp_valid;
    logic [XLEN-1:0] w_dev_resp_rdata;
    logic            w_timeout;

    // Ready depends only on state so the core never sees a valid->ready path.
    assign w_req_ready = (r_state == S_IDLE);
    assign w_accept    = io_core.req_valid & w_req_ready;

    // UART register is matched on the word address; the RAM window check uses
    // a wrapping subtraction so a non-zero base needs no second comparator.
    assign w_mem_off  = io_core.req_addr - MEM_BASE;
    assign w_hit_uart = (io_core.req_addr[XLEN-1:2] == UART_TX_ADDR[XLEN-1:2]);
    assign w_hit_mem  = (w_mem_off < MEM_SIZE);
    assign w_mapped   = w_hit_uart | w_hit_mem;

    // Only the selected device's handshake inputs are ever observed.
    assign w_dev_ready      = r_sel_uart ? io_uart.req_ready  : io_mem.req_ready;
    assign w_dev_resp_valid = r_sel_uart ? io_uart.resp_valid : io_mem.resp_valid;
    assign w_dev_resp_rdata = r_sel_uart ? io_uart.resp_rdata : io_mem.resp_rdata;

`ifdef MMIO_ROUTER_TIMEOUT_EN
    localparam int unsigned      TO_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] r_to_cnt;

    // Counts cycles spent on a device exchange; held at zero while idle so it
    // starts from zero on every entry to ISSUE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (r_state == S_ISSUE || r_state == S_WAIT_RESP) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end else begin
            r_to_cnt <= '0;
        end
    end

    assign w_timeout = ((r_state == S_ISSUE) || (r_state == S_WAIT_RESP)) &&
                       (r_to_cnt == TO_LAST);
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign w_timeout            = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. In ISSUE a timeout wins over a late handshake; in
    // WAIT_RESP a response arriving on the last allowed cycle still completes.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_mapped ? S_ISSUE : S_RESPOND;
                end
            end
            S_ISSUE: begin
                if (w_timeout) begin
                    w_next_state = S_RESPOND;
                end else if (w_dev_ready) begin
                    w_next_state = S_WAIT_RESP;
                end
            end
            S_WAIT_RESP: begin
                if (w_dev_resp_valid || w_timeout) begin
                    w_next_state = S_RESPOND;
                end
            end
            S_RESPOND: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Request latch and response capture. rdata/err hold between responses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_wen      <= 1'b0;
            r_wdata    <= '0;
            r_sel_uart <= 1'b0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr     <= io_core.req_addr;
                        r_wen      <= io_core.req_wen;
                        r_wdata    <= io_core.req_wdata;
                        r_sel_uart <= w_hit_uart;
                        if (!w_mapped) begin
                            r_rdata <= '0;
                            r_err   <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (w_timeout) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end
                end
                S_WAIT_RESP: begin
                    if (w_dev_resp_valid) begin
                        r_rdata <= w_dev_resp_rdata;
                        r_err   <= 1'b0;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign io_core.req_ready  = w_req_ready;
    assign io_core.resp_valid = (r_state == S_RESPOND);
    assign io_core.resp_rdata = r_rdata;
    assign io_core.resp_err   = r_err;

    // Device valids come straight from state, so they are glitch-free and
    // stay high with stable fields until the handshake.
    assign io_mem.req_valid  = (r_state == S_ISSUE) & ~r_sel_uart;
    assign io_mem.req_addr   = r_addr;
    assign io_mem.req_wen    = r_wen;
    assign io_mem.req_wdata  = r_wdata;

    assign io_uart.req_valid = (r_state == S_ISSUE) & r_sel_uart;
    assign io_uart.req_addr  = r_addr;
    assign io_uart.req_wen   = r_wen;
    assign io_uart.req_wdata = r_wdata;

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mmio_bus_router.sv
// Self-checking bench for mmio_bus_router. Expected responses ({err, rdata})
// are pushed to exp_q when a request is driven and popped when the router
// raises resp_valid.

module tb_mmio_bus_router;

    localparam int unsigned XLEN = 32;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [31:0] UART_A = 32'hff00_0000;
    localparam logic [31:0] UART_RD = 32'h0000_0055;
    localparam logic [31:0] MEM_K = 32'h5a5a_0000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] dbg_state;
    int         n_tests = 0;
    int         n_fail = 0;
    logic [XLEN:0] exp_q[$];

    mmio_core_if #(.XLEN(XLEN)) core_bus();
    mmio_dev_if  #(.XLEN(XLEN)) mem_bus();
    mmio_dev_if  #(.XLEN(XLEN)) uart_bus();

    mmio_bus_router #(
        .XLEN(XLEN),
        .MEM_BASE(32'h0000_0000),
        .MEM_SIZE(32'h0001_0000),
        .UART_TX_ADDR(32'hff00_0000),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .io_core(core_bus),
        .io_mem(mem_bus),
        .io_uart(uart_bus),
        .o_dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_devices(input logic mr, input logic mv, input logic ur, input logic uv);
        mem_bus.req_ready   = mr;
        mem_bus.resp_valid  = mv;
        uart_bus.req_ready  = ur;
        uart_bus.resp_valid = uv;
    endtask

    // Presents one request for a single edge; caller makes sure req_ready is high.
    task automatic drive_req(input logic [31:0] addr, input logic wen, input logic [31:0] wdata);
        core_bus.req_valid = 1'b1;
        core_bus.req_addr  = addr;
        core_bus.req_wen   = wen;
        core_bus.req_wdata = wdata;
        tick();
        core_bus.req_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_tests++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
        n_tests++; if (core_bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=1", core_bus.req_ready); end
        n_tests++; if (core_bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got=%b exp=0", core_bus.resp_valid); end
        n_tests++; if (core_bus.resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err got=%b exp=0", core_bus.resp_err); end
        n_tests++; if (core_bus.resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_resp_rdata got=%h exp=0", core_bus.resp_rdata); end
        n_tests++; if ({mem_bus.req_valid, uart_bus.req_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_dev_valid got=%b exp=00", {mem_bus.req_valid, uart_bus.req_valid}); end
        n_tests++; if ({mem_bus.req_addr, mem_bus.req_wen, mem_bus.req_wdata} !== 65'h0) begin n_fail++; $display("FAIL reset_latch got=%h exp=0", {mem_bus.req_addr, mem_bus.req_wen, mem_bus.req_wdata}); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_uart_write();
        int n_uart = 0;
        int n_mem = 0;
        int bad_fields = 0;
        int got_at = 0;
        logic [XLEN:0] exp_v;
        // RAM side is ready and responding, but must never be touched.
        set_devices(1'b1, 1'b1, 1'b1, 1'b1);
        uart_bus.resp_rdata = UART_RD;
        mem_bus.resp_rdata  = 32'h1234_5678;
        n_tests++; if (core_bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL uart_pre_ready got=%b exp=1", core_bus.req_ready); end
        exp_q.push_back({1'b0, UART_RD});
        drive_req(UART_A, 1'b1, 32'h0000_0041);
        for (int c = 1; c <= 10; c++) begin
            if (uart_bus.req_valid) begin
                n_uart++;
                if (uart_bus.req_addr !== UART_A || uart_bus.req_wen !== 1'b1 || uart_bus.req_wdata !== 32'h41) bad_fields++;
            end
            if (mem_bus.req_valid) n_mem++;
            if (core_bus.resp_valid) begin
                got_at = c;
                n_tests++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL uart_resp_unexpected got=%h exp=none", core_bus.resp_rdata); end
                else begin
                    exp_v = exp_q.pop_front();
                    if ({core_bus.resp_err, core_bus.resp_rdata} !== exp_v) begin n_fail++; $display("FAIL uart_resp got=%h exp=%h", {core_bus.resp_err, core_bus.resp_rdata}, exp_v); end
                end
            end
            tick();
            if (got_at != 0) break;
        end
        n_tests++; if (got_at !== 3) begin n_fail++; $display("FAIL uart_latency got=%0d exp=3", got_at); end
        n_tests++; if (n_uart !== 1) begin n_fail++; $display("FAIL uart_valid_cycles got=%0d exp=1", n_uart); end
        n_tests++; if (bad_fields !== 0) begin n_fail++; $display("FAIL uart_fields got=%0d bad exp=0", bad_fields); end
        n_tests++; if (n_mem !== 0) begin n_fail++; $display("FAIL uart_mem_touched got=%0d exp=0", n_mem); end
        n_tests++; if (core_bus.resp_valid !== 1'b0 || core_bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL uart_after got=%b%b exp=01", core_bus.resp_valid, core_bus.req_ready); end
        set_devices(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_ram_backpressure();
        int n_mem = 0;
        int n_uart = 0;
        int bad_fields = 0;
        int ready_high = 0;
        int got_at = 0;
        logic [XLEN:0] exp_v;
        // UART keeps signalling a response; it must be ignored.
        set_devices(1'b0, 1'b0, 1'b1, 1'b1);
        exp_q.push_back({1'b0, 32'hdeadbeef});
        drive_req(32'h0000_0100, 1'b0, 32'h1357_9bdf);
        for (int c = 1; c <= 20; c++) begin
            mem_bus.req_ready  = (c >= 6);
            mem_bus.resp_valid = (c == 8);
            mem_bus.resp_rdata = (c == 8) ? 32'hdeadbeef : 32'h0badf00d;
            if (mem_bus.req_valid) begin
                n_mem++;
                if (mem_bus.req_addr !== 32'h100 || mem_bus.req_wen !== 1'b0 || mem_bus.req_wdata !== 32'h1357_9bdf) bad_fields++;
            end
            if (uart_bus.req_valid) n_uart++;
            if (core_bus.req_ready) ready_high++;
            if (core_bus.resp_valid) begin
                got_at = c;
                n_tests++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL ram_resp_unexpected got=%h exp=none", core_bus.resp_rdata); end
                else begin
                    exp_v = exp_q.pop_front();
                    if ({core_bus.resp_err, core_bus.resp_rdata} !== exp_v) begin n_fail++; $display("FAIL ram_resp got=%h exp=%h", {core_bus.resp_err, core_bus.resp_rdata}, exp_v); end
                end
            end
            tick();
            if (got_at != 0) break;
        end
        n_tests++; if (n_mem !== 6) begin n_fail++; $display("FAIL ram_valid_cycles got=%0d exp=6", n_mem); end
        n_tests++; if (bad_fields !== 0) begin n_fail++; $display("FAIL ram_fields_stable got=%0d bad exp=0", bad_fields); end
        n_tests++; if (ready_high !== 0) begin n_fail++; $display("FAIL ram_req_ready_busy got=%0d cycles exp=0", ready_high); end
        n_tests++; if (n_uart !== 0) begin n_fail++; $display("FAIL ram_uart_touched got=%0d exp=0", n_uart); end
        n_tests++; if (got_at !== 9) begin n_fail++; $display("FAIL ram_latency got=%0d exp=9", got_at); end
        set_devices(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_unmapped();
        int got_at = 0;
        logic [XLEN:0] exp_v;
        set_devices(1'b1, 1'b1, 1'b1, 1'b1);
        uart_bus.resp_rdata = UART_RD;
        mem_bus.resp_rdata  = 32'h7777_7777;
        exp_q.push_back({1'b1, 32'h0});
        drive_req(32'h8000_0000, 1'b0, 32'hcafe_0000);
        n_tests++; if (core_bus.resp_valid !== 1'b1) begin n_fail++; $display("FAIL unmapped_latency got=%b exp=1", core_bus.resp_valid); end
        n_tests++;
        if (core_bus.resp_valid !== 1'b1 || exp_q.size() == 0) begin n_fail++; $display("FAIL unmapped_resp got=no_response exp=%h", {1'b1, 32'h0}); end
        else begin
            exp_v = exp_q.pop_front();
            if ({core_bus.resp_err, core_bus.resp_rdata} !== exp_v) begin n_fail++; $display("FAIL unmapped_resp got=%h exp=%h", {core_bus.resp_err, core_bus.resp_rdata}, exp_v); end
        end
        n_tests++; if ({mem_bus.req_valid, uart_bus.req_valid} !== 2'b00) begin n_fail++; $display("FAIL unmapped_dev_valid got=%b exp=00", {mem_bus.req_valid, uart_bus.req_valid}); end
        // Next request is presented during RESPOND and must land on the first IDLE cycle.
        core_bus.req_valid = 1'b1;
        core_bus.req_addr  = UART_A;
        core_bus.req_wen   = 1'b1;
        core_bus.req_wdata = 32'h0000_0042;
        tick();
        n_tests++; if (core_bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL unmapped_next_ready got=%b exp=1", core_bus.req_ready); end
        if (core_bus.req_ready) exp_q.push_back({1'b0, UART_RD});
        tick();
        core_bus.req_valid = 1'b0;
        n_tests++; if (uart_bus.req_valid !== 1'b1 || uart_bus.req_wdata !== 32'h42) begin n_fail++; $display("FAIL unmapped_next_issue got=%b/%h exp=1/00000042", uart_bus.req_valid, uart_bus.req_wdata); end
        for (int c = 3; c <= 10; c++) begin
            if (core_bus.resp_valid) begin
                got_at = c;
                n_tests++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL unmapped_next_unexpected got=%h exp=none", core_bus.resp_rdata); end
                else begin
                    exp_v = exp_q.pop_front();
                    if ({core_bus.resp_err, core_bus.resp_rdata} !== exp_v) begin n_fail++; $display("FAIL unmapped_next_resp got=%h exp=%h", {core_bus.resp_err, core_bus.resp_rdata}, exp_v); end
                end
            end
            tick();
            if (got_at != 0) break;
        end
        n_tests++; if (got_at !== 5) begin n_fail++; $display("FAIL unmapped_next_latency got=%0d exp=5", got_at); end
        set_devices(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_decode_boundary();
        // kind: 0 = unmapped, 1 = RAM, 2 = UART
        logic [31:0] addrs [6] = '{32'h0000_0000, 32'h0000_fffc, 32'h0001_0000,
                                   32'hff00_0003, 32'hff00_0004, 32'hffff_fffc};
        int kinds [6] = '{1, 1, 0, 2, 0, 0};
        logic [XLEN:0] exp_v;
        logic [1:0] exp_sel;
        int got_at;
        int exp_lat;
        set_devices(1'b1, 1'b1, 1'b1, 1'b1);
        uart_bus.resp_rdata = UART_RD;
        mem_bus.resp_rdata  = 32'h1111_2222;
        for (int i = 0; i < 6; i++) begin
            exp_sel = (kinds[i] == 1) ? 2'b10 : (kinds[i] == 2) ? 2'b01 : 2'b00;
            exp_lat = (kinds[i] == 0) ? 1 : 3;
            if (kinds[i] == 0)      exp_q.push_back({1'b1, 32'h0});
            else if (kinds[i] == 1) exp_q.push_back({1'b0, 32'h1111_2222});
            else                    exp_q.push_back({1'b0, UART_RD});
            got_at = 0;
            drive_req(addrs[i], 1'b0, 32'h0);
            n_tests++; if ({mem_bus.req_valid, uart_bus.req_valid} !== exp_sel) begin n_fail++; $display("FAIL decode_sel addr=%h got=%b exp=%b", addrs[i], {mem_bus.req_valid, uart_bus.req_valid}, exp_sel); end
            for (int c = 1; c <= 6; c++) begin
                if (core_bus.resp_valid) begin
                    got_at = c;
                    n_tests++;
                    if (exp_q.size() == 0) begin n_fail++; $display("FAIL decode_unexpected addr=%h got=%h exp=none", addrs[i], core_bus.resp_rdata); end
                    else begin
                        exp_v = exp_q.pop_front();
                        if ({core_bus.resp_err, core_bus.resp_rdata} !== exp_v) begin n_fail++; $display("FAIL decode_resp addr=%h got=%h exp=%h", addrs[i], {core_bus.resp_err, core_bus.resp_rdata}, exp_v); end
                    end
                end
                tick();
                if (got_at != 0) break;
            end
            n_tests++; if (got_at !== exp_lat) begin n_fail++; $display("FAIL decode_latency addr=%h got=%0d exp=%0d", addrs[i], got_at, exp_lat); end
        end
        set_devices(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_midop();
        int spurious = 0;
        int not_idle = 0;
        set_devices(1'b1, 1'b0, 1'b0, 1'b0);
        drive_req(32'h0000_0200, 1'b0, 32'h0);
        tick();
        n_tests++; if (dbg_state !== ST_WAIT) begin n_fail++; $display("FAIL midrst_reach_wait got=%0d exp=%0d", dbg_state, ST_WAIT); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_tests++; if (dbg_state !== ST_IDLE || core_bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_idle got=%0d/%b exp=0/1", dbg_state, core_bus.req_ready); end
        n_tests++; if ({core_bus.resp_valid, mem_bus.req_valid, uart_bus.req_valid} !== 3'b000) begin n_fail++; $display("FAIL midrst_valids got=%b exp=000", {core_bus.resp_valid, mem_bus.req_valid, uart_bus.req_valid}); end
        // Late response from the aborted request.
        mem_bus.resp_valid = 1'b1;
        mem_bus.resp_rdata = 32'hbad0_0bad;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (core_bus.resp_valid) spurious++;
            if (dbg_state !== ST_IDLE) not_idle++;
        end
        n_tests++; if (spurious !== 0) begin n_fail++; $display("FAIL midrst_late_resp got=%0d exp=0", spurious); end
        n_tests++; if (not_idle !== 0) begin n_fail++; $display("FAIL midrst_stay_idle got=%0d exp=0", not_idle); end
        set_devices(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        localparam int N = 24;
        logic [31:0] addrs [N];
        logic [XLEN:0] exps [N];
        logic [XLEN:0] exp_v;
        int total = 0;
        int idx = 0;
        int got = 0;
        int last_c = -1;
        int r;
        for (int i = 0; i < N; i++) begin
            r = $urandom_range(0, 3);
            if (r == 1) begin
                addrs[i] = UART_A | 32'($urandom_range(0, 3));
                exps[i]  = {1'b0, UART_RD};
                total += 4;
            end else if (r == 2) begin
                addrs[i] = $urandom_range(32'h0001_0000, 32'hfeff_fffc);
                exps[i]  = {1'b1, 32'h0};
                total += 2;
            end else begin
                addrs[i] = {14'h0, 16'($urandom_range(0, 16'h3fff)), 2'b00};
                exps[i]  = {1'b0, addrs[i] ^ MEM_K};
                total += 4;
            end
        end
        set_devices(1'b1, 1'b1, 1'b1, 1'b1);
        uart_bus.resp_rdata = UART_RD;
        for (int c = 0; c < 400 && got < N; c++) begin
            if (idx < N) begin
                core_bus.req_valid = 1'b1;
                core_bus.req_addr  = addrs[idx];
                core_bus.req_wen   = idx[0];
                core_bus.req_wdata = 32'($urandom);
            end else begin
                core_bus.req_valid = 1'b0;
            end
            // RAM model returns a function of the address it was sent.
            mem_bus.resp_rdata = mem_bus.req_addr ^ MEM_K;
            if (core_bus.resp_valid) begin
                got++;
                last_c = c;
                n_tests++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_unexpected got=%h exp=none", core_bus.resp_rdata); end
                else begin
                    exp_v = exp_q.pop_front();
                    if ({core_bus.resp_err, core_bus.resp_rdata} !== exp_v) begin n_fail++; $display("FAIL b2b_resp n=%0d got=%h exp=%h", got, {core_bus.resp_err, core_bus.resp_rdata}, exp_v); end
                end
            end
            if (core_bus.req_valid && core_bus.req_ready) begin
                exp_q.push_back(exps[idx]);
                idx++;
            end
            tick();
        end
        core_bus.req_valid = 1'b0;
        n_tests++; if (got !== N) begin n_fail++; $display("FAIL b2b_count got=%0d exp=%0d", got, N); end
        n_tests++; if (last_c !== total - 1) begin n_fail++; $display("FAIL b2b_throughput got=%0d exp=%0d", last_c, total - 1); end
        set_devices(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

`ifdef MMIO_ROUTER_TIMEOUT_EN
    task automatic test_timeout();
        int got_at = 0;
        int n_mem = 0;
        logic [XLEN:0] exp_v;
        set_devices(1'b0, 1'b0, 1'b0, 1'b0);
        exp_q.push_back({1'b1, 32'h0});
        drive_req(32'h0000_0300, 1'b0, 32'h0);
        n_tests++; if (dbg_state !== ST_ISSUE) begin n_fail++; $display("FAIL timeout_issue got=%0d exp=%0d", dbg_state, ST_ISSUE); end
        for (int c = 1; c <= 40; c++) begin
            if (mem_bus.req_valid) n_mem++;
            if (core_bus.resp_valid) begin
                got_at = c;
                n_tests++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL timeout_unexpected got=%h exp=none", core_bus.resp_rdata); end
                else begin
                    exp_v = exp_q.pop_front();
                    if ({core_bus.resp_err, core_bus.resp_rdata} !== exp_v) begin n_fail++; $display("FAIL timeout_resp got=%h exp=%h", {core_bus.resp_err, core_bus.resp_rdata}, exp_v); end
                end
            end
            tick();
            if (got_at != 0) break;
        end
        n_tests++; if (got_at !== 17) begin n_fail++; $display("FAIL timeout_latency got=%0d exp=17", got_at); end
        n_tests++; if (n_mem !== 16) begin n_fail++; $display("FAIL timeout_valid_cycles got=%0d exp=16", n_mem); end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        rst_n              = 1'b0;
        core_bus.req_valid = 1'b0;
        core_bus.req_addr  = '0;
        core_bus.req_wen   = 1'b0;
        core_bus.req_wdata = '0;
        mem_bus.resp_rdata  = '0;
        uart_bus.resp_rdata = '0;
        set_devices(1'b0, 1'b0, 1'b0, 1'b0);

        test_reset();
        test_uart_write();
        test_ram_backpressure();
        test_unmapped();
        test_decode_boundary();
        test_reset_midop();
        test_back_to_back();
`ifdef MMIO_ROUTER_TIMEOUT_EN
        test_timeout();
`endif
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
